serial_compare_seq: RTL and testbench

Sequential front-end for the 3-bit magnitude comparator. It deserialises two 3-bit operands from a 1-bit stream, MSB first, and holds them stable on `a`/`b` while the combinational comparator settles. It then captures the comparator's 3-bit result, presents it with a one-cycle valid strobe, and keeps a saturating count of equal results. It sits directly upstream of the comparator and also consumes the comparator's output.

---
 rtl/serial_compare_seq_if.sv | 29 ++
 rtl/serial_compare_seq.sv | 143 ++++++++++++++
 tb/tb_serial_compare_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_compare_seq_if.sv
// Operand/result bundle between the serial front-end and its driver/comparator side.
interface serial_compare_seq_if #(
   parameter int unsigned W     = 3,
   parameter int unsigned CNT_W = 4
);
   logic             start;
   logic             sin;
   logic             sin_valid;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [W-1:0]     o;
   logic [W-1:0]     res;
   logic             res_valid;
   logic             busy;
   logic             err;
   logic [CNT_W-1:0] eq_cnt;

   // Driver side: issues requests and serial bits, returns the comparator result.
   modport master (
      output start, sin, sin_valid, o,
      input  a, b, res, res_valid, busy, err, eq_cnt
   );

   // Front-end side.
   modport slave (
      input  start, sin, sin_valid, o,
      output a, b, res, res_valid, busy, err, eq_cnt
   );
endinterface

// File: rtl/serial_compare_seq.sv
// Serial operand loader for the 3-bit magnitude comparator: shifts in A then B
// MSB first, holds them for one compare cycle, captures the one-hot result and
// keeps a saturating count of equal results.
module serial_compare_seq #(
   parameter int unsigned W     = 3,
   parameter int unsigned CNT_W = 4
) (
   input logic                clk,
   input logic                rst,
   serial_compare_seq_if.slave bus
);

   localparam int unsigned BIT_CNT_W = $clog2(W);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(W - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT_A = 3'd1,
      SHIFT_B = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [W-1:0]         a_q, a_d;
   logic [W-1:0]         b_q, b_d;
   logic [W-1:0]         res_q, res_d;
   logic                 res_valid_q, res_valid_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     eq_cnt_q, eq_cnt_d;
   logic                 onehot_c;

   // The comparator output must have exactly one bit set to be trusted.
   assign onehot_c = (bus.o != '0) && ((bus.o & (bus.o - W'(1))) == '0);

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      err_d     = err_q;
      eq_cnt_d  = eq_cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = SHIFT_A;
               bit_cnt_d = '0;
               a_d       = '0;
               b_d       = '0;
            end
         end
         SHIFT_A: begin
            if (bus.sin_valid) begin
               a_d = {a_q[W-2:0], bus.sin};
               if (bit_cnt_q == LAST_BIT) begin
                  state_d   = SHIFT_B;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         SHIFT_B: begin
            if (bus.sin_valid) begin
               b_d = {b_q[W-2:0], bus.sin};
               if (bit_cnt_q == LAST_BIT) begin
                  state_d   = COMPARE;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         COMPARE: begin
            if (onehot_c) begin
               res_d = bus.o;
            end else begin
               res_d = '0;
               err_d = 1'b1;
            end
            if ((bus.o == W'(3'b010)) && (eq_cnt_q != '1)) begin
               eq_cnt_d = eq_cnt_q + CNT_W'(1);
            end
            state_d = DONE;
         end
         DONE: begin
            if (bus.start) begin
               state_d   = SHIFT_A;
               bit_cnt_d = '0;
               a_d       = '0;
               b_d       = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      res_valid_d = (state_d == DONE);
      busy_d      = (state_d == SHIFT_A) || (state_d == SHIFT_B) || (state_d == COMPARE);
   end

   // State and output registers; synchronous reset discards any partial operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         eq_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         eq_cnt_q    <= eq_cnt_d;
      end
   end

   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.res       = res_q;
   assign bus.res_valid = res_valid_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;
   assign bus.eq_cnt    = eq_cnt_q;

endmodule

// File: tb/tb_serial_compare_seq.sv
// Scoreboard bench for serial_compare_seq with a behavioural comparator model.
module tb_serial_compare_seq;

   localparam int unsigned W     = 3;
   localparam int unsigned CNT_W = 4;
   localparam int          EQ_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force_bad = 1'b0;

   always #5 clk = ~clk;

   serial_compare_seq_if #(.W(W), .CNT_W(CNT_W)) bus ();

   serial_compare_seq #(.W(W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Downstream comparator model, with an override that produces an illegal code.
   assign bus.o = force_bad ? 3'b110 :
                  (bus.a > bus.b)  ? 3'b100 :
                  (bus.a == bus.b) ? 3'b010 : 3'b001;

   typedef struct {
      logic [2:0] res;
      logic       err;
      int         eq;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic err_m  = 1'b0;
   int   eq_m   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] cmp_ref(input int av, input int bv);
      if (av > bv) return 3'b100;
      if (av == bv) return 3'b010;
      return 3'b001;
   endfunction

   // Monitor: every strobe must match the oldest pending expectation.
   exp_t m_e;
   always @(negedge clk) begin
      if (!rst && bus.res_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: res_valid=1 at cycle %0d, required no pending result", cyc);
         end else begin
            m_e = sb.pop_front();
            chk("res", 32'(bus.res), 32'(m_e.res));
            chk("err", 32'(bus.err), 32'(m_e.err));
            chk("eq_cnt", 32'(bus.eq_cnt), 32'(m_e.eq));
            chk("strobe_cycle", 32'(cyc), 32'(m_e.due));
         end
      end
   end

   // One compare: stalls[2k+:2] idle cycles precede serial bit k (A msb first, then B).
   task automatic run_op(input logic [2:0] av, input logic [2:0] bv, input logic [11:0] stalls,
                         input bit bad, input bit start_in_b, input bit chain);
      int         total;
      logic [5:0] bits;
      exp_t       e;
      total = 0;
      for (int k = 0; k < 6; k++) total += int'(stalls[2*k +: 2]);
      bits = {av, bv};
      if (bad) begin
         e.res = 3'b000;
         err_m = 1'b1;
      end else begin
         e.res = cmp_ref(int'(av), int'(bv));
         if (e.res == 3'b010 && eq_m < EQ_MAX) eq_m++;
      end
      e.err = err_m;
      e.eq  = eq_m;
      e.due = cyc + 8 + total;
      sb.push_back(e);

      bus.start     = 1'b1;
      bus.sin_valid = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         for (int s = 0; s < int'(stalls[2*k +: 2]); s++) begin
            bus.sin_valid = 1'b0;
            bus.sin       = 1'($urandom);
            @(negedge clk);
         end
         bus.sin_valid = 1'b1;
         bus.sin       = bits[5-k];
         bus.start     = start_in_b && (k == 4);
         @(negedge clk);
      end
      bus.start     = 1'b0;
      bus.sin_valid = 1'b0;
      chk("a_in_compare", 32'(bus.a), 32'(av));
      chk("b_in_compare", 32'(bus.b), 32'(bv));
      chk("busy_in_compare", 32'(bus.busy), 32'd1);
      force_bad = bad;
      @(negedge clk);
      force_bad = 1'b0;
      chk("busy_in_done", 32'(bus.busy), 32'd0);
      if (!chain) @(negedge clk);
   endtask

   task automatic check_all_zero(input string name);
      chk(name, 32'({bus.a, bus.b, bus.res, bus.res_valid, bus.busy, bus.err, bus.eq_cnt}), 32'd0);
   endtask

   logic [2:0] rav, rbv;

   initial begin
      bus.start     = 1'b0;
      bus.sin       = 1'b0;
      bus.sin_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset then idle with toggling serial inputs.
      for (int i = 0; i < 10; i++) begin
         check_all_zero("idle_outputs");
         bus.sin       = ~bus.sin;
         bus.sin_valid = 1'($urandom);
         @(negedge clk);
      end
      bus.sin_valid = 1'b0;

      // Greater-than.
      run_op(3'd5, 3'd3, 12'h000, 1'b0, 1'b0, 1'b0);
      // Equal then less-than, back-to-back.
      run_op(3'd6, 3'd6, 12'h000, 1'b0, 1'b0, 1'b1);
      run_op(3'd2, 3'd7, 12'h000, 1'b0, 1'b0, 1'b0);
      // Stalls (2 before A bit 1, 1 before B bit 1) and start ignored in SHIFT_B.
      run_op(3'd3, 3'd4, 12'h108, 1'b0, 1'b1, 1'b0);
      repeat (12) begin
         chk("no_second_op_busy", 32'(bus.busy), 32'd0);
         @(negedge clk);
      end

      // Randomised operations.
      for (int i = 0; i < 24; i++) begin
         rav = 3'($urandom_range(0, 7));
         rbv = ($urandom_range(0, 3) == 0) ? rav : 3'($urandom_range(0, 7));
         run_op(rav, rbv, 12'($urandom), 1'b0, 1'($urandom), (i != 23) && 1'($urandom));
      end

      // Illegal comparator code, then a normal op to show err is sticky.
      run_op(3'd5, 3'd2, 12'h000, 1'b1, 1'b0, 1'b0);
      run_op(3'd1, 3'd4, 12'h000, 1'b0, 1'b0, 1'b0);
      chk("err_sticky", 32'(bus.err), 32'd1);

      // Reset during SHIFT_B discards the partial operand and clears err.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.sin_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.sin = 1'($urandom);
         @(negedge clk);
      end
      bus.sin_valid = 1'b0;
      chk("busy_before_rst", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      err_m = 1'b0;
      eq_m  = 0;
      for (int i = 0; i < 4; i++) begin
         check_all_zero("after_mid_rst");
         @(negedge clk);
      end

      // Counter saturation: 17 equal compares back-to-back.
      for (int i = 0; i < 17; i++) begin
         rav = 3'($urandom_range(0, 7));
         run_op(rav, rav, 12'h000, 1'b0, 1'b0, i != 16);
      end
      chk("eq_cnt_saturated", 32'(bus.eq_cnt), 32'(EQ_MAX));

      repeat (4) @(negedge clk);
      chk("pending_results", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
